requant_drain: RTL and testbench

Output stage directly downstream of the NPU PE array. Captures the full set of signed PE accumulators in one handshake and requantizes each one to a signed int8. Requantization is a fixed-point scale multiply, a rounding arithmetic right shift, a zero-point add and saturation. Results stream out one lane per beat on a valid/ready interface, in lane order, under full backpressure.

---
 rtl/requant_drain.sv | 157 +++++++++++++++
 tb/tb_requant_drain.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/requant_drain.sv
// requant_drain: captures one vector of signed PE accumulators and streams each lane out
// as a saturated signed integer after scale multiply, rounding shift and zero-point add.
module requant_drain #(
    parameter int NUM_ACC     = 4,
    parameter int ACC_WIDTH   = 24,
    parameter int MULT_WIDTH  = 16,
    parameter int SHIFT_WIDTH = 5,
    parameter int OUT_WIDTH   = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           acc_valid,
    output logic                           acc_ready,
    input  logic [NUM_ACC*ACC_WIDTH-1:0]   acc_flat,
    input  logic [MULT_WIDTH-1:0]          scale_mult,
    input  logic [SHIFT_WIDTH-1:0]         scale_shift,
    input  logic [OUT_WIDTH-1:0]           zero_point,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [OUT_WIDTH-1:0]           out_data,
    output logic [$clog2(NUM_ACC)-1:0]     out_index,
    output logic                           out_last,
    output logic                           busy
);

    localparam int IDX_W = $clog2(NUM_ACC);
    localparam int P_W   = ACC_WIDTH + MULT_WIDTH + 1;
    localparam int G_W   = P_W + 1;
    localparam int V_W   = G_W + 1;
    localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NUM_ACC - 1);
    localparam logic signed [V_W-1:0] SAT_MAX = V_W'((1 << (OUT_WIDTH - 1)) - 1);
    localparam logic signed [V_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic {IDLE, DRAIN} state_t;

    state_t state_q, state_d;

    logic signed [ACC_WIDTH-1:0] acc_q [NUM_ACC];
    logic [MULT_WIDTH-1:0]       mult_q;
    logic [SHIFT_WIDTH-1:0]      shift_q;
    logic signed [OUT_WIDTH-1:0] zp_q;

    logic [IDX_W-1:0]            cnt_q;
    logic                        issue_done_q;
    logic                        rst_done_q;

    logic                        s1_valid_q;
    logic [IDX_W-1:0]            s1_idx_q;
    logic signed [P_W-1:0]       s1_p_q, s1_p_d;

    logic                        out_valid_q, out_last_q, out_last_d;
    logic [IDX_W-1:0]            out_index_q;
    logic [OUT_WIDTH-1:0]        out_data_q, out_data_d;

    logic signed [G_W-1:0]       p_ext, rnd, shifted;
    logic signed [V_W-1:0]       sum;

    logic accept, advance, issuing, last_hs;

    assign accept  = acc_valid && acc_ready;
    assign advance = !out_valid_q || out_ready;
    assign issuing = (state_q == DRAIN) && !issue_done_q;
    assign last_hs = out_valid_q && out_ready && out_last_q;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default assignment first so no path through the block infers a latch.
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)  state_d = DRAIN;
            DRAIN:   if (last_hs) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic; ready stays low for one cycle after reset so a reset pulse is visible upstream.
    always_comb begin
        acc_ready = (state_q == IDLE) && rst_done_q && !rst;
        busy      = (state_q == DRAIN);
    end

    // S1: signed lane times zero-extended multiplier.
    always_comb begin
        s1_p_d = P_W'(acc_q[cnt_q]) * P_W'($signed({1'b0, mult_q}));
    end

    // S2: the guard bit keeps the rounding add from overflowing; shift 0 adds nothing.
    always_comb begin
        p_ext = G_W'(s1_p_q);
        rnd   = '0;
        if (shift_q != '0) rnd = G_W'(1) << (shift_q - SHIFT_WIDTH'(1));
        shifted = (p_ext + rnd) >>> shift_q;
        sum     = V_W'(shifted) + V_W'(zp_q);
        out_data_d = sum[OUT_WIDTH-1:0];
        if (sum > SAT_MAX)      out_data_d = SAT_MAX[OUT_WIDTH-1:0];
        else if (sum < SAT_MIN) out_data_d = SAT_MIN[OUT_WIDTH-1:0];
        out_last_d = (s1_idx_q == LAST_IDX);
    end

    // Control and output registers; all stages and the issue counter hold when advance is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            rst_done_q   <= 1'b0;
            cnt_q        <= '0;
            issue_done_q <= 1'b0;
            s1_valid_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_data_q   <= '0;
            out_index_q  <= '0;
        end else begin
            rst_done_q <= 1'b1;
            if (accept) begin
                cnt_q        <= '0;
                issue_done_q <= 1'b0;
            end else if (advance && issuing) begin
                cnt_q        <= cnt_q + IDX_W'(1);
                issue_done_q <= (cnt_q == LAST_IDX);
            end
            if (advance) begin
                s1_valid_q  <= issuing;
                out_valid_q <= s1_valid_q;
                out_last_q  <= s1_valid_q && out_last_d;
                if (s1_valid_q) begin
                    out_data_q  <= out_data_d;
                    out_index_q <= s1_idx_q;
                end
            end
        end
    end

    // NOTE: pure datapath storage is not reset; every use is qualified by a reset valid bit.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < NUM_ACC; i++) acc_q[i] <= acc_flat[i*ACC_WIDTH +: ACC_WIDTH];
            mult_q  <= scale_mult;
            shift_q <= scale_shift;
            zp_q    <= zero_point;
        end
        if (advance && issuing) begin
            s1_p_q   <= s1_p_d;
            s1_idx_q <= cnt_q;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_index = out_index_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_requant_drain.sv
// tb_requant_drain: directed vectors with hand-computed int8 results for requant_drain.
module tb_requant_drain;

    localparam int NUM_ACC = 4;
    localparam int ACC_W   = 24;

    logic                       clk;
    logic                       rst;
    logic                       acc_valid;
    logic                       acc_ready;
    logic [NUM_ACC*ACC_W-1:0]   acc_flat;
    logic [15:0]                scale_mult;
    logic [4:0]                 scale_shift;
    logic [7:0]                 zero_point;
    logic                       out_valid;
    logic                       out_ready;
    logic signed [7:0]          out_data;
    logic [1:0]                 out_index;
    logic                       out_last;
    logic                       busy;

    int n_checks = 0;
    int n_errors = 0;

    logic signed [7:0] beat_data [$];
    int                beat_idx  [$];
    logic              beat_last [$];
    logic signed [7:0] exp_v [4];

    requant_drain dut (
        .clk         (clk),
        .rst         (rst),
        .acc_valid   (acc_valid),
        .acc_ready   (acc_ready),
        .acc_flat    (acc_flat),
        .scale_mult  (scale_mult),
        .scale_shift (scale_shift),
        .zero_point  (zero_point),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_index   (out_index),
        .out_last    (out_last),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Beats are recorded half a cycle before the edge that accepts them.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            beat_data.push_back(out_data);
            beat_idx.push_back(int'(out_index));
            beat_last.push_back(out_last);
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NUM_ACC*ACC_W-1:0] pack4(input int a0, input int a1,
                                                       input int a2, input int a3);
        pack4 = {ACC_W'(a3), ACC_W'(a2), ACC_W'(a1), ACC_W'(a0)};
    endfunction

    task automatic set_exp(input int a0, input int a1, input int a2, input int a3);
        exp_v[0] = 8'(a0);
        exp_v[1] = 8'(a1);
        exp_v[2] = 8'(a2);
        exp_v[3] = 8'(a3);
    endtask

    // Presents a vector and returns just after the edge on which it was accepted.
    task automatic send(input string tag, input logic [NUM_ACC*ACC_W-1:0] flat,
                        input logic [15:0] mult, input logic [4:0] shift, input logic [7:0] zp);
        acc_flat    = flat;
        scale_mult  = mult;
        scale_shift = shift;
        zero_point  = zp;
        acc_valid   = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (acc_ready) begin
                step();
                acc_valid = 1'b0;
                return;
            end
            step();
        end
        check({tag, "_accept_timeout"}, int'(acc_ready), 1);
        acc_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 200) begin
            step();
            n++;
        end
        check({tag, "_idle"}, int'(busy), 0);
    endtask

    // Pops four recorded beats and compares them against exp_v.
    task automatic expect_beats(input string tag);
        for (int i = 0; i < NUM_ACC; i++) begin
            if (beat_data.size() > 0) begin
                check($sformatf("%s_data%0d", tag, i), int'(beat_data.pop_front()), int'(exp_v[i]));
                check($sformatf("%s_idx%0d", tag, i), beat_idx.pop_front(), i);
                check($sformatf("%s_last%0d", tag, i), int'(beat_last.pop_front()), int'(i == NUM_ACC - 1));
            end
        end
    endtask

    task automatic clear_beats();
        beat_data.delete();
        beat_idx.delete();
        beat_last.delete();
    endtask

    initial begin
        int n;
        rst         = 1'b1;
        acc_valid   = 1'b0;
        acc_flat    = '0;
        scale_mult  = '0;
        scale_shift = '0;
        zero_point  = '0;
        out_ready   = 1'b0;

        // Reset state.
        repeat (3) step();
        check("rst_acc_ready", int'(acc_ready), 0);
        check("rst_busy",      int'(busy), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_last",  int'(out_last), 0);
        check("rst_out_data",  int'(out_data), 0);
        check("rst_out_index", int'(out_index), 0);
        rst       = 1'b0;
        out_ready = 1'b1;
        step();
        check("rst_release_ready", int'(acc_ready), 1);

        // Passthrough with latency and ready-return timing.
        send("pt", pack4(5, -3, 127, -128), 16'd1, 5'd0, 8'd0);
        check("pt_t0_valid", int'(out_valid), 0);
        check("pt_t0_busy",  int'(busy), 1);
        check("pt_t0_ready", int'(acc_ready), 0);
        step();
        check("pt_t1_valid", int'(out_valid), 0);
        step();
        check("pt_t2_valid", int'(out_valid), 1);
        check("pt_t2_index", int'(out_index), 0);
        n = 2;
        while (!acc_ready && n < 60) begin
            step();
            n++;
        end
        check("pt_ready_edge", n, NUM_ACC + 2);
        check("pt_count", beat_data.size(), 4);
        set_exp(5, -3, 127, -128);
        expect_beats("pt");

        // Rounding: half toward +inf.
        send("rnd", pack4(6, 5, -6, -5), 16'd1, 5'd2, 8'd0);
        wait_idle("rnd");
        check("rnd_count", beat_data.size(), 4);
        set_exp(2, 1, -1, -1);
        expect_beats("rnd");

        // Scaling by 16384 / 2^16.
        send("scl", pack4(300, -300, 0, 4), 16'd16384, 5'd16, 8'd0);
        wait_idle("scl");
        check("scl_count", beat_data.size(), 4);
        set_exp(75, -75, 0, 1);
        expect_beats("scl");

        // Extreme accumulators, largest multiplier and shift.
        send("ext", pack4(8388607, -8388608, 1, 0), 16'hFFFF, 5'd31, 8'd0);
        wait_idle("ext");
        check("ext_count", beat_data.size(), 4);
        set_exp(127, -128, 0, 0);
        expect_beats("ext");

        // Saturation without and with zero point.
        send("sat0", pack4(1000, -1000, 120, -130), 16'd1, 5'd0, 8'd0);
        wait_idle("sat0");
        check("sat0_count", beat_data.size(), 4);
        set_exp(127, -128, 120, -128);
        expect_beats("sat0");
        send("sat10", pack4(1000, -1000, 120, -130), 16'd1, 5'd0, 8'd10);
        wait_idle("sat10");
        check("sat10_count", beat_data.size(), 4);
        set_exp(127, -128, 127, -120);
        expect_beats("sat10");

        // Backpressure: stall three cycles on lane 1.
        send("bp", pack4(10, 20, 30, 40), 16'd3, 5'd1, 8'hFB);
        step();
        step();
        step();
        check("bp_pre_index", int'(out_index), 1);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("bp_stall%0d_valid", i), int'(out_valid), 1);
            check($sformatf("bp_stall%0d_index", i), int'(out_index), 1);
            check($sformatf("bp_stall%0d_data", i),  int'(out_data), 25);
            check($sformatf("bp_stall%0d_ready", i), int'(acc_ready), 0);
        end
        out_ready = 1'b1;
        wait_idle("bp");
        check("bp_count", beat_data.size(), 4);
        set_exp(10, 25, 40, 55);
        expect_beats("bp");

        // Config isolation and no overlap: second vector presented mid-drain.
        send("cfga", pack4(-20, 40, -60, 80), 16'd2, 5'd0, 8'd1);
        send("cfgb", pack4(100, -100, 7, -7), 16'd3, 5'd2, 8'hFE);
        check("cfg_a_done_first", beat_data.size(), 4);
        wait_idle("cfg");
        check("cfg_count", beat_data.size(), 8);
        set_exp(-39, 81, -119, 127);
        expect_beats("cfga");
        set_exp(73, -77, 3, -7);
        expect_beats("cfgb");

        // Reset while lane 2 is presented.
        send("mrst", pack4(1, 2, 3, 4), 16'd1, 5'd0, 8'd0);
        step();
        step();
        step();
        step();
        check("mrst_pre_index", int'(out_index), 2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mrst_valid", int'(out_valid), 0);
        check("mrst_busy",  int'(busy), 0);
        check("mrst_ready", int'(acc_ready), 0);
        check("mrst_data",  int'(out_data), 0);
        check("mrst_index", int'(out_index), 0);
        check("mrst_beats_before", beat_data.size(), 2);
        clear_beats();
        step();
        check("mrst_ready_after", int'(acc_ready), 1);
        check("mrst_valid_after", int'(out_valid), 0);
        send("post", pack4(9, -9, 50, -50), 16'd1, 5'd0, 8'd0);
        wait_idle("post");
        check("post_count", beat_data.size(), 4);
        set_exp(9, -9, 50, -50);
        expect_beats("post");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
